fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Display-side reader for the thermal camera framebuffer.
- Pulls pixels over a valid/ready stream and stages each source line in a two-line ping-pong line buffer.
- Replays each line scale_p times horizontally and vertically to build an upscaled raster with hsync, vsync and data-enable.
- Sits between the framebuffer output and the display/encoder pins.

Parameters:
- pixel_bytes_p, 2, bytes per pixel.
- line_pixels_p, 5, source pixels per line.
- frame_lines_p, 5, source lines per frame.
- scale_p, 2, integer upscale factor (>=1).
- h_front_p, 2; h_sync_p, 3; h_back_p, 3: horizontal blanking widths in clocks.
- v_front_p, 1; v_sync_p, 2; v_back_p, 2: vertical blanking widths in lines.

Ports:
- clk_i  in  1  pixel clock.
- reset_ni  in  1  asynchronous active-low reset.
- pixel_i  in  8*pixel_bytes_p  pixel from framebuffer.
- valid_i  in  1  pixel_i valid.
- ready_o  out  1  block accepts pixel_i this cycle.
- pixel_o  out  8*pixel_bytes_p  raster pixel; 0 outside de_o.
- de_o  out  1  active-video data enable.
- hsync_o  out  1  horizontal sync, active low.
- vsync_o  out  1  vertical sync, active low.
- underflow_o  out  1  sticky; a raster line was shown before its source line was filled.

Behaviour:
- Derived constants:
  - H_ACT = line_pixels_p*scale_p; H_TOT = H_ACT + h_front_p + h_sync_p + h_back_p.
  - V_ACT = frame_lines_p*scale_p; V_TOT likewise from the v_* widths.
  - Defaults: H_ACT 10, H_TOT 18, V_ACT 10, V_TOT 15.
- Raster counters h_cnt (0..H_TOT-1) and v_cnt (0..V_TOT-1).
  - Per-line region order: active, front, sync, back.
  - h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0.
- Reset values:
  - h_cnt=0, v_cnt=V_ACT (start of vertical blanking, giving prefetch time).
  - de_o=0, hsync_o=1, vsync_o=1, pixel_o=0, underflow_o=0.
  - Both line-buffer halves empty; fill half=0; display half=0.
  - ready_o reflects fill state (1 one cycle after reset release).
- Fill engine:
  - States: IDLE, FILL.
  - IDLE→FILL when the current fill half is empty.
  - In FILL, ready_o=1; each valid_i&ready_o writes pixel_i at fill_x and increments fill_x.
  - At fill_x==line_pixels_p-1 with handshake: mark the half full, toggle the fill half, return to IDLE.
  - ready_o is registered and deasserts the cycle after the last accept; no pixel is accepted while ready_o=0.
- Source line counting is implicit: pixel N*line_pixels_p of the stream is the start of source line N mod frame_lines_p. There is no resync input.
- Display engine:
  - Source x = h_cnt/scale_p.
  - Source line advances every scale_p active raster lines.
  - After the last replay of a source line (end of h_cnt==H_ACT-1 on its final raster line), the display half is marked empty and the display half toggles.
  - Empty and full may be set on the same cycle for different halves; both take effect.
- Underflow:
  - Checked at h_cnt==0 of each active raster line: if the display half is not full, that whole raster line outputs pixel_o=0 with de_o=1, and underflow_o sets.
  - The half is not advanced or freed early.
  - underflow_o clears only on reset.
- Latency:
  - Line buffer is a synchronous read (1 cycle) plus an output register.
  - pixel_o, de_o, hsync_o and vsync_o are all delayed 2 clocks from the counters and are mutually aligned.
  - hsync_o=0 while h_cnt is in the sync region; vsync_o=0 for all clocks of lines in the v sync region.
- Asynchronous reset mid-line or mid-fill:
  - Returns every register to its reset value immediately.
  - Partial line contents are discarded.
  - The upstream stream alignment is the framebuffer's responsibility; it is reset together with this block.

Optional Feature:
- FB_SCANOUT_TEST_PATTERN_EN defined:
  - Adds input pattern_en_i (1 bit).
  - When high, pixel_o during active video = {v_cnt[7:0], h_cnt[7:0]}, zero-extended or truncated to the pixel width.
  - The fill engine keeps draining the stream normally.
  - underflow_o is not updated while the pattern is shown.
- Undefined: no port; behaviour as above.

Decomposition:
- Package fb_scanout_pkg holds fill_state_t {IDLE, FILL} and helper functions for H_TOT/V_TOT.
- Sub-module fb_line_buffer (ping-pong, 2*line_pixels_p entries) wraps ram_1r1w_sync with half-select addressing and owns the full flags.

Test Plan:
- Reset release, valid_i held 1 with incrementing pixels 0..24 (defaults) -> ready_o high from cycle 1; first raster line shows 0,0,1,1,2,2,3,3,4,4 with de_o high 10 clocks; line repeated on next raster line; underflow_o stays 0.
- Sync timing -> hsync_o low exactly 3 clocks starting 12 clocks after de_o rises (2 clocks after de_o falls); vsync_o low for 2 full lines; frame period 18*15=270 clocks.
- valid_i held 0 after line 0 is filled -> source line 1 raster lines show 0 with de_o=1, underflow_o sets and stays 1 for the rest of the run.
- Backpressure: ready_o drops after 10 pixels (both halves full); the next pixel is accepted only after the display frees half 0 (after 2 raster lines of line 0).
- Assert reset_ni low mid-fill at fill_x=3 -> all outputs at reset values asynchronously; after release, fill restarts at fill_x=0 into half 0.
- With FB_SCANOUT_TEST_PATTERN_EN and pattern_en_i=1 -> pixel at h_cnt=7, v_cnt=3 reads 16'h0307.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// Shared types and raster-geometry helpers for the fb_scanout framebuffer reader.
package fb_scanout_pkg;

    typedef enum logic {IDLE, FILL} fill_state_t;

    function automatic int unsigned h_tot(input int unsigned line_pixels, input int unsigned scale,
                                          input int unsigned front, input int unsigned sync,
                                          input int unsigned back);
        return line_pixels * scale + front + sync + back;
    endfunction

    function automatic int unsigned v_tot(input int unsigned frame_lines, input int unsigned scale,
                                          input int unsigned front, input int unsigned sync,
                                          input int unsigned back);
        return frame_lines * scale + front + sync + back;
    endfunction

    // Never returns 0 so degenerate sizes still give a legal vector width.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Valid/ready pixel stream from the framebuffer into fb_scanout.
interface fb_scanout_if #(
    parameter int unsigned PixelW = 16
) ();
    logic [PixelW-1:0] pixel;
    logic              valid;
    logic              ready;

    modport master (output pixel, output valid, input ready);
    modport slave  (input pixel, input valid, output ready);
endinterface

// File: rtl/fb_line_buffer.sv
// Two-half ping-pong line store; each half holds one source line and has a full flag.
module fb_line_buffer
    import fb_scanout_pkg::*;
#(
    parameter int unsigned LinePixels = 5,
    parameter int unsigned Width      = 16,
    localparam int unsigned XW = clog2_min1(LinePixels),
    localparam int unsigned Aw = clog2_min1(2 * LinePixels)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic             wr_half_i,
    input  logic [XW-1:0]    wr_x_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             set_full_i,
    input  logic             rd_half_i,
    input  logic [XW-1:0]    rd_x_i,
    output logic [Width-1:0] rd_data_o,
    input  logic             clr_full_i,
    input  logic             clr_half_i,
    output logic [1:0]       full_o
);
    logic [Aw-1:0] waddr, raddr;
    logic [1:0]    full_q, full_d;

    assign waddr = wr_half_i ? Aw'(LinePixels) + Aw'(wr_x_i) : Aw'(wr_x_i);
    assign raddr = rd_half_i ? Aw'(LinePixels) + Aw'(rd_x_i) : Aw'(rd_x_i);

    // Set is applied after clear so a same-cycle collision keeps the freshly filled line.
    always_comb begin
        full_d = full_q;
        if (clr_full_i) full_d[clr_half_i] = 1'b0;
        if (set_full_i) full_d[wr_half_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) full_q <= 2'b00;
        else         full_q <= full_d;
    end

    assign full_o = full_q;

    ram_1r1w_sync #(
        .Depth(2 * LinePixels),
        .Width(Width)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (wr_en_i),
        .waddr_i(waddr),
        .wdata_i(wr_data_i),
        .raddr_i(raddr),
        .rdata_o(rd_data_o)
    );
endmodule

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM: one write port, one synchronous read port.
module ram_1r1w_sync #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8,
    localparam int unsigned Aw = (Depth <= 2) ? 1 : $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: stages source lines and replays them as an upscaled raster.
// Define FB_SCANOUT_TEST_PATTERN_EN to add pattern_en_i (coordinate test pattern).
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int unsigned pixel_bytes_p = 2,
    parameter int unsigned line_pixels_p = 5,
    parameter int unsigned frame_lines_p = 5,
    parameter int unsigned scale_p       = 2,
    parameter int unsigned h_front_p     = 2,
    parameter int unsigned h_sync_p      = 3,
    parameter int unsigned h_back_p      = 3,
    parameter int unsigned v_front_p     = 1,
    parameter int unsigned v_sync_p      = 2,
    parameter int unsigned v_back_p      = 2,
    localparam int unsigned PixelW = 8 * pixel_bytes_p
) (
    input  logic              clk_i,
    input  logic              reset_ni,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    input  logic              pattern_en_i,
`endif
    fb_scanout_if.slave       src,
    output logic [PixelW-1:0] pixel_o,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              underflow_o
);
    localparam int unsigned HAct = line_pixels_p * scale_p;
    localparam int unsigned VAct = frame_lines_p * scale_p;
    localparam int unsigned HTot = h_tot(line_pixels_p, scale_p, h_front_p, h_sync_p, h_back_p);
    localparam int unsigned VTot = v_tot(frame_lines_p, scale_p, v_front_p, v_sync_p, v_back_p);
    localparam int unsigned HW = clog2_min1(HTot + 1);
    localparam int unsigned VW = clog2_min1(VTot + 1);
    localparam int unsigned XW = clog2_min1(line_pixels_p);
    localparam int unsigned RW = clog2_min1(scale_p);

    localparam logic [HW-1:0] HActC    = HW'(HAct);
    localparam logic [HW-1:0] HActLast = HW'(HAct - 1);
    localparam logic [HW-1:0] HLast    = HW'(HTot - 1);
    localparam logic [HW-1:0] HSyncBeg = HW'(HAct + h_front_p);
    localparam logic [HW-1:0] HSyncEnd = HW'(HAct + h_front_p + h_sync_p);
    localparam logic [VW-1:0] VActC    = VW'(VAct);
    localparam logic [VW-1:0] VLast    = VW'(VTot - 1);
    localparam logic [VW-1:0] VSyncBeg = VW'(VAct + v_front_p);
    localparam logic [VW-1:0] VSyncEnd = VW'(VAct + v_front_p + v_sync_p);
    localparam logic [XW-1:0] XLast    = XW'(line_pixels_p - 1);
    localparam logic [RW-1:0] RepLast  = RW'(scale_p - 1);

    logic pat_en;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    assign pat_en = pattern_en_i;
`else
    assign pat_en = 1'b0;
`endif

    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    fill_state_t       state_q, state_d;
    logic              ready_q, ready_d;
    logic [XW-1:0]     fill_x_q, fill_x_d;
    logic              fill_half_q, fill_half_d;
    logic              disp_half_q, disp_half_d;
    logic [RW-1:0]     rep_q, rep_d;
    logic              line_bad_q, line_bad_d;
    logic              underflow_q, underflow_d;
    logic              de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic              bad1_q, bad1_d, pat1_q, pat1_d;
    logic [PixelW-1:0] pat_px1_q, pat_px1_d;
    logic [PixelW-1:0] pixel_q, pixel_d;
    logic              de_q, hs_q, vs_q;

    logic              hs_accept, set_full, clr_full, active, line_start, full_now;
    logic [1:0]        full;
    logic [XW-1:0]     rd_x;
    logic [PixelW-1:0] rd_data;

    assign active     = (h_cnt_q < HActC) && (v_cnt_q < VActC);
    assign line_start = active && (h_cnt_q == '0);
    assign full_now   = full[disp_half_q];
    assign rd_x       = XW'(h_cnt_q / HW'(scale_p));
    assign hs_accept  = src.valid && ready_q;

    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HLast) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + VW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        fill_x_d    = fill_x_q;
        fill_half_d = fill_half_q;
        set_full    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!full[fill_half_q]) begin
                    state_d = FILL;
                    ready_d = 1'b1;
                end
            end
            FILL: begin
                if (hs_accept) begin
                    if (fill_x_q == XLast) begin
                        set_full    = 1'b1;
                        fill_x_d    = '0;
                        fill_half_d = ~fill_half_q;
                        state_d     = IDLE;
                        ready_d     = 1'b0;
                    end else begin
                        fill_x_d = fill_x_q + XW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Source line retires after its last replay, regardless of whether it underflowed.
    always_comb begin
        rep_d       = rep_q;
        disp_half_d = disp_half_q;
        clr_full    = 1'b0;
        if (active && (h_cnt_q == HActLast)) begin
            if (rep_q == RepLast) begin
                rep_d       = '0;
                disp_half_d = ~disp_half_q;
                clr_full    = 1'b1;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end
    end

    always_comb begin
        line_bad_d  = line_start ? !full_now : line_bad_q;
        underflow_d = underflow_q | (line_start && !full_now && !pat_en);
        de1_d       = active;
        hs1_d       = !((h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd));
        vs1_d       = !((v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd));
        bad1_d      = line_bad_d;
        pat1_d      = pat_en;
        pat_px1_d   = PixelW'({8'(v_cnt_q), 8'(h_cnt_q)});
        pixel_d     = '0;
        if (de1_q) pixel_d = pat1_q ? pat_px1_q : (bad1_q ? '0 : rd_data);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= VActC;
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            fill_x_q    <= '0;
            fill_half_q <= 1'b0;
            disp_half_q <= 1'b0;
            rep_q       <= '0;
            line_bad_q  <= 1'b0;
            underflow_q <= 1'b0;
            de1_q       <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            bad1_q      <= 1'b0;
            pat1_q      <= 1'b0;
            pat_px1_q   <= '0;
            pixel_q     <= '0;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            state_q     <= state_d;
            ready_q     <= ready_d;
            fill_x_q    <= fill_x_d;
            fill_half_q <= fill_half_d;
            disp_half_q <= disp_half_d;
            rep_q       <= rep_d;
            line_bad_q  <= line_bad_d;
            underflow_q <= underflow_d;
            de1_q       <= de1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            bad1_q      <= bad1_d;
            pat1_q      <= pat1_d;
            pat_px1_q   <= pat_px1_d;
            pixel_q     <= pixel_d;
            de_q        <= de1_q;
            hs_q        <= hs1_q;
            vs_q        <= vs1_q;
        end
    end

    fb_line_buffer #(
        .LinePixels(line_pixels_p),
        .Width     (PixelW)
    ) u_line_buffer (
        .clk_i     (clk_i),
        .rst_ni    (reset_ni),
        .wr_en_i   (hs_accept),
        .wr_half_i (fill_half_q),
        .wr_x_i    (fill_x_q),
        .wr_data_i (src.pixel),
        .set_full_i(set_full),
        .rd_half_i (disp_half_q),
        .rd_x_i    (rd_x),
        .rd_data_o (rd_data),
        .clr_full_i(clr_full),
        .clr_half_i(disp_half_q),
        .full_o    (full)
    );

    assign src.ready   = ready_q;
    assign pixel_o     = pixel_q;
    assign de_o        = de_q;
    assign hsync_o     = hs_q;
    assign vsync_o     = vs_q;
    assign underflow_o = underflow_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout with default geometry (H_TOT 18, V_TOT 15, scale 2).
module tb_fb_scanout;
    localparam int unsigned PixelW = 16;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic [PixelW-1:0] pixel_o;
    logic              de_o, hsync_o, vsync_o, underflow_o;
    int                checks = 0;
    int                failures = 0;
    int                accepted;
    int                cyc;
    logic              hs;

    fb_scanout_if #(.PixelW(PixelW)) src_if ();

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    logic pattern_en = 1'b0;
`endif

    fb_scanout dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        .pattern_en_i(pattern_en),
`endif
        .src        (src_if),
        .pixel_o    (pixel_o),
        .de_o       (de_o),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .underflow_o(underflow_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Upstream model: pixel value equals the number of pixels accepted since reset.
    initial begin : source
        accepted     = 0;
        src_if.pixel = '0;
        forever begin
            @(posedge clk_i);
            hs = src_if.valid && src_if.ready && reset_ni;
            #1;
            if (!reset_ni) accepted = 0;
            else if (hs) accepted++;
            src_if.pixel = PixelW'(accepted);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge following posedge number k after reset release.
    task automatic to_edge(input int k);
        while (cyc < k) begin
            @(posedge clk_i);
            cyc++;
        end
        @(negedge clk_i);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_de"}, 32'(de_o), 32'd0);
        chk({tag, "_hsync"}, 32'(hsync_o), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync_o), 32'd1);
        chk({tag, "_pixel"}, 32'(pixel_o), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow_o), 32'd0);
        chk({tag, "_ready"}, 32'(src_if.ready), 32'd0);
    endtask

    logic [15:0] exp_l0 [10] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3,
                                 16'd4, 16'd4};

    initial begin : main
        reset_ni     = 1'b0;
        src_if.valid = 1'b0;
        cyc          = 0;
        repeat (3) @(negedge clk_i);
        chk_reset_outputs("reset");

        // Partial fill, then asynchronous reset mid-fill.
        reset_ni     = 1'b1;
        src_if.valid = 1'b1;
        to_edge(1);
        chk("ready_after_release", 32'(src_if.ready), 32'd1);
        to_edge(4);
        chk("midfill_accepted", 32'(accepted), 32'd3);
        reset_ni = 1'b0;
        #1;
        chk_reset_outputs("midfill_async");
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        cyc      = 0;

        // Phase A: continuous stream.
        to_edge(6);
        chk("ready_dip_after_line", 32'(src_if.ready), 32'd0);
        to_edge(7);
        chk("ready_second_half", 32'(src_if.ready), 32'd1);
        to_edge(12);
        chk("backpressure_ready", 32'(src_if.ready), 32'd0);
        chk("backpressure_count", 32'(accepted), 32'd10);
        to_edge(19);
        chk("vsync_before", 32'(vsync_o), 32'd1);
        to_edge(20);
        chk("vsync_first", 32'(vsync_o), 32'd0);
        to_edge(55);
        chk("vsync_last", 32'(vsync_o), 32'd0);
        to_edge(56);
        chk("vsync_after", 32'(vsync_o), 32'd1);
        to_edge(91);
        chk("de_before_active", 32'(de_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            to_edge(92 + i);
            chk("line0_rep0_de", 32'(de_o), 32'd1);
            chk("line0_rep0_px", 32'(pixel_o), 32'(exp_l0[i]));
        end
        to_edge(102);
        chk("de_after_active", 32'(de_o), 32'd0);
        chk("pixel_blank", 32'(pixel_o), 32'd0);
        to_edge(103);
        chk("hsync_before", 32'(hsync_o), 32'd1);
        to_edge(104);
        chk("hsync_first", 32'(hsync_o), 32'd0);
        to_edge(106);
        chk("hsync_last", 32'(hsync_o), 32'd0);
        to_edge(107);
        chk("hsync_after", 32'(hsync_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            to_edge(110 + i);
            chk("line0_rep1_px", 32'(pixel_o), 32'(exp_l0[i]));
            if (i == 8) chk("ready_held_low", 32'(src_if.ready), 32'd0);
            if (i == 9) chk("ready_after_free", 32'(src_if.ready), 32'd1);
        end
        to_edge(120);
        chk("accept_after_free", 32'(accepted), 32'd11);
        to_edge(128);
        chk("line1_px0", 32'(pixel_o), 32'd5);
        to_edge(129);
        chk("line1_px1", 32'(pixel_o), 32'd5);
        to_edge(137);
        chk("line1_px9", 32'(pixel_o), 32'd9);
        to_edge(361);
        chk("frame2_de_before", 32'(de_o), 32'd0);
        to_edge(362);
        chk("frame2_de", 32'(de_o), 32'd1);
        chk("frame2_px0", 32'(pixel_o), 32'd25);
        chk("no_underflow", 32'(underflow_o), 32'd0);
        to_edge(364);
        chk("frame2_px2", 32'(pixel_o), 32'd26);

        // Phase B: stream stops after source line 0.
        reset_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        cyc      = 0;
        to_edge(6);
        chk("starve_count", 32'(accepted), 32'd5);
        src_if.valid = 1'b0;
        to_edge(94);
        chk("starve_line0_px", 32'(pixel_o), 32'd1);
        to_edge(126);
        chk("underflow_pre", 32'(underflow_o), 32'd0);
        to_edge(127);
        chk("underflow_set", 32'(underflow_o), 32'd1);
        to_edge(132);
        chk("underflow_de", 32'(de_o), 32'd1);
        chk("underflow_px", 32'(pixel_o), 32'd0);
        to_edge(300);
        chk("underflow_sticky", 32'(underflow_o), 32'd1);
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        to_edge(400);
        pattern_en = 1'b1;
        to_edge(423);
        chk("pattern_px", 32'(pixel_o), 32'h0307);
`endif
        to_edge(425);
        chk("midline_de", 32'(de_o), 32'd1);
        chk("midline_underflow", 32'(underflow_o), 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk_reset_outputs("midline_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
